seq_controller: RTL and testbench

//  Sequenced successor to the combinational decoder. Same opcode/branch_bits decode,

---
 rtl/seq_controller.sv | 137 +++++++++++++
 tb/tb_seq_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - sequenced instruction decoder with run FSM, load stalls, program index and cycle counter
module seq_controller #(
  parameter int MEM_LAT   = 2,
  parameter int NUM_PROGS = 3,
  parameter int CNT_W     = 16,
  localparam int PW       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             instr_valid,
  input  logic [2:0]       opcode,
  input  logic [1:0]       branch_bits,
  output logic             wr_en,
  output logic             sub,
  output logic             alu_src,
  output logic             shift_left,
  output logic             use_lut,
  output logic             mem_write,
  output logic             branch,
  output logic             sel_rd,
  output logic             alu_mem_sel,
  output logic             next_branch_selector,
  output logic [1:0]       alu_op,
  output logic [1:0]       branch_sel,
  output logic [1:0]       sel_rs,
  output logic             pc_en,
  output logic             pc_load,
  output logic [PW-1:0]    prog_idx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q;
  logic            done_q;
  logic [PW-1:0]   prog_idx_q;
  logic [CNT_W-1:0] cnt_q;

  logic dec_wr_en, dec_branch, dec_nbs, dec_mem_write, halt;
  logic issue, wait_exit, is_load, stall, halting;

  // Raw decode, independent of FSM state
  always_comb begin
    dec_wr_en     = 1'b1;
    if (opcode == 3'b001 || opcode == 3'b010) dec_wr_en = 1'b0;
    else if (opcode == 3'b011)                dec_wr_en = ~branch_bits[1];
    sub           = (opcode == 3'b010) & ~branch_bits[1];
    alu_src       = (opcode[2:1] == 2'b00);
    sel_rd        = (opcode[2:1] == 2'b00);
    shift_left    = branch_bits[1];
    use_lut       = branch_bits[0];
    dec_branch    = (opcode == 3'b010);
    alu_mem_sel   = (opcode == 3'b011) & ~branch_bits[1];
    dec_nbs       = (dec_branch & ~&branch_bits) | (opcode == 3'b001);
    dec_mem_write = (opcode == 3'b011) & (branch_bits == 2'b10);
    halt          = (opcode == 3'b011) & (branch_bits == 2'b11);
    branch_sel    = branch_bits;
    case (opcode)
      3'b110:  alu_op = 2'b01;
      3'b101:  alu_op = 2'b10;
      3'b100:  alu_op = 2'b11;
      default: alu_op = 2'b00;
    endcase
    case (opcode)
      3'b100:                 sel_rs = 2'b01;
      3'b101, 3'b110, 3'b111: sel_rs = 2'b00;
      3'b010, 3'b011:         sel_rs = 2'b10;
      default:                sel_rs = 2'b11;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_exit = (state_q == WAIT) && (wait_cnt_q == '0);
    issue     = ((state_q == RUN) && instr_valid) || wait_exit;
    is_load   = issue && (opcode == 3'b011) && (branch_bits == 2'b00);
    stall     = (state_q == RUN) && is_load && (MEM_LAT > 0);
    halting   = (state_q == RUN) && issue && halt;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN: begin
        if (stall)        state_d = WAIT;
        else if (halting) state_d = DONE;
      end
      WAIT:    if (wait_exit) state_d = RUN;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Strobes that change architectural state only fire on an issuing cycle
  assign wr_en                = dec_wr_en & issue & ~stall;
  assign pc_en                = issue & ~stall & ~halting;
  assign mem_write            = dec_mem_write & issue;
  assign branch               = dec_branch & issue;
  assign next_branch_selector = dec_nbs & issue;
  assign pc_load              = (state_q == LOAD);
  assign busy                 = (state_q == LOAD) || (state_q == RUN) || (state_q == WAIT);
  assign done                 = done_q;
  assign prog_idx             = prog_idx_q;
  assign cycle_count          = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      prog_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (stall)
        wait_cnt_q <= WAIT_INIT;
      else if (state_q == WAIT && wait_cnt_q != '0)
        wait_cnt_q <= wait_cnt_q - 1'b1;
      if (halting) begin
        done_q     <= 1'b1;
        prog_idx_q <= (prog_idx_q == PW'(NUM_PROGS - 1)) ? '0 : prog_idx_q + 1'b1;
      end else if (state_q == DONE && start) begin
        done_q <= 1'b0;
      end
      if (state_q == LOAD)
        cnt_q <= '0;
      else if ((state_q == RUN || state_q == WAIT) && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - directed self-checking bench for seq_controller
module tb_seq_controller;

  logic       clk, rst_n, start, instr_valid;
  logic [2:0] opcode;
  logic [1:0] branch_bits;
  logic wr_en, sub, alu_src, shift_left, use_lut, mem_write, branch, sel_rd;
  logic alu_mem_sel, next_branch_selector, pc_en, pc_load, busy, done;
  logic [1:0] alu_op, branch_sel, sel_rs;
  logic [1:0] prog_idx;
  logic [3:0] cycle_count;

  int tests = 0;
  int fails = 0;

  seq_controller #(.MEM_LAT(2), .NUM_PROGS(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_valid(instr_valid),
    .opcode(opcode), .branch_bits(branch_bits),
    .wr_en(wr_en), .sub(sub), .alu_src(alu_src), .shift_left(shift_left),
    .use_lut(use_lut), .mem_write(mem_write), .branch(branch), .sel_rd(sel_rd),
    .alu_mem_sel(alu_mem_sel), .next_branch_selector(next_branch_selector),
    .alu_op(alu_op), .branch_sel(branch_sel), .sel_rs(sel_rs),
    .pc_en(pc_en), .pc_load(pc_load), .prog_idx(prog_idx), .busy(busy),
    .done(done), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic v, input logic [2:0] op, input logic [1:0] bb);
    start = s; instr_valid = v; opcode = op; branch_bits = bb;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 3'b000, 2'b00);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prog_idx", prog_idx, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_en", pc_en, 0);
    tick();
    rst_n = 1'b1;

    // Program 0: three ALU instructions
    set_in(1, 1, 3'b111, 2'b00);
    chk("idle_pc_en", pc_en, 0);
    chk("idle_wr_en", wr_en, 0);
    tick();
    set_in(0, 1, 3'b111, 2'b00);
    chk("load_pc_load", pc_load, 1);
    chk("load_busy", busy, 1);
    chk("load_pc_en", pc_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_pc_en", pc_en, 1);
      chk("run_wr_en", wr_en, 1);
      chk("run_alu_op", alu_op, 2'b00);
      chk("run_pc_load", pc_load, 0);
      chk("run_cycle_count", cycle_count, i);
    end
    tick();
    set_in(1, 0, 3'b111, 2'b00);
    chk("alu_cycle_count", cycle_count, 3);
    chk("bubble_pc_en", pc_en, 0);
    chk("bubble_wr_en", wr_en, 0);
    tick();
    chk("start_in_run_pc_load", pc_load, 0);
    chk("start_in_run_busy", busy, 1);
    chk("start_in_run_cc", cycle_count, 4);

    // Memory load with MEM_LAT=2
    set_in(0, 1, 3'b011, 2'b00);
    chk("ld0_pc_en", pc_en, 0);
    chk("ld0_wr_en", wr_en, 0);
    chk("ld0_alu_mem_sel", alu_mem_sel, 1);
    tick();
    chk("ld1_pc_en", pc_en, 0);
    chk("ld1_wr_en", wr_en, 0);
    chk("ld1_alu_mem_sel", alu_mem_sel, 1);
    chk("ld1_busy", busy, 1);
    tick();
    chk("ld2_wr_en", wr_en, 1);
    chk("ld2_pc_en", pc_en, 1);
    chk("ld2_alu_mem_sel", alu_mem_sel, 1);
    chk("ld2_cycle_count", cycle_count, 6);
    tick();

    // Branches, bubble, store
    set_in(0, 1, 3'b010, 2'b11);
    chk("br11_branch", branch, 1);
    chk("br11_nbs", next_branch_selector, 0);
    chk("br11_wr_en", wr_en, 0);
    chk("br11_pc_en", pc_en, 1);
    chk("br11_sel_rs", sel_rs, 2'b10);
    set_in(0, 1, 3'b010, 2'b00);
    chk("br00_sub", sub, 1);
    chk("br00_nbs", next_branch_selector, 1);
    set_in(0, 0, 3'b010, 2'b00);
    chk("brbub_branch", branch, 0);
    chk("brbub_nbs", next_branch_selector, 0);
    chk("brbub_pc_en", pc_en, 0);
    set_in(0, 1, 3'b011, 2'b10);
    chk("st_mem_write", mem_write, 1);
    chk("st_wr_en", wr_en, 0);
    chk("st_pc_en", pc_en, 1);
    set_in(0, 1, 3'b100, 2'b01);
    chk("op100_alu_op", alu_op, 2'b11);
    chk("op100_sel_rs", sel_rs, 2'b01);
    chk("op100_use_lut", use_lut, 1);
    set_in(0, 1, 3'b001, 2'b10);
    chk("op001_nbs", next_branch_selector, 1);
    chk("op001_wr_en", wr_en, 0);
    chk("op001_alu_src", alu_src, 1);
    chk("op001_sel_rs", sel_rs, 2'b11);

    // Halt
    set_in(0, 1, 3'b011, 2'b11);
    chk("halt_pc_en", pc_en, 0);
    chk("halt_wr_en", wr_en, 0);
    tick();
    set_in(0, 0, 3'b000, 2'b00);
    chk("h0_done", done, 1);
    chk("h0_busy", busy, 0);
    chk("h0_prog_idx", prog_idx, 1);
    chk("h0_pc_en", pc_en, 0);
    chk("h0_cycle_count", cycle_count, 8);
    tick();
    chk("h0_cc_held", cycle_count, 8);

    // Programs 1 and 2: restart from DONE, halt immediately
    for (int p = 0; p < 2; p++) begin
      set_in(1, 0, 3'b000, 2'b00);
      tick();
      set_in(0, 1, 3'b011, 2'b11);
      chk("restart_done", done, 0);
      chk("restart_pc_load", pc_load, 1);
      tick();
      chk("restart_cc_zero", cycle_count, 0);
      tick();
      set_in(0, 0, 3'b000, 2'b00);
      chk("hp_done", done, 1);
      chk("hp_prog_idx", prog_idx, (p == 0) ? 2 : 0);
      chk("hp_cycle_count", cycle_count, 1);
    end

    // Long run saturates the 4-bit counter, then reset mid-WAIT
    set_in(1, 0, 3'b000, 2'b00);
    tick();
    set_in(0, 1, 3'b111, 2'b00);
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cycle_count", cycle_count, 15);
    chk("sat_pc_en", pc_en, 1);
    set_in(0, 1, 3'b011, 2'b00);
    tick();
    chk("midwait_busy", busy, 1);
    chk("midwait_pc_en", pc_en, 0);
    chk("midwait_cc", cycle_count, 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pc_en", pc_en, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_pc_load", pc_load, 0);
    chk("arst_done", done, 0);
    chk("arst_cycle_count", cycle_count, 0);
    chk("arst_prog_idx", prog_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pc_en", pc_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
